// File: rtl/get_target_pkg.sv
// rtl/get_target_pkg.sv - shared constants and types for the get_target colour tracker
//
// Purpose : target count, coordinate width, run-length ceiling and the
//           3-bit compressed colour code of every target.
// Ports   : none (package).

package get_target_pkg;

   localparam int NUM_TARGETS = 4;
   localparam int COORD_W     = 11;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [2:0]         rgb_t;

   // Longest run a tracker can count; runs keep matching but stop growing here.
   localparam coord_t RUN_MAX = '1;

   localparam rgb_t RGB_RED    = 3'b100;
   localparam rgb_t RGB_GREEN  = 3'b010;
   localparam rgb_t RGB_BLUE   = 3'b001;
   localparam rgb_t RGB_YELLOW = 3'b110;

   // Target index i lives in slice [i]: 0 red, 1 green, 2 blue, 3 yellow.
   localparam logic [NUM_TARGETS-1:0][2:0] TARGET_CODES =
      {RGB_YELLOW, RGB_BLUE, RGB_GREEN, RGB_RED};

   // Saturating increment shared by the column counter and the run counters.
   function automatic coord_t sat_inc(input coord_t value, input coord_t limit);
      return (value >= limit) ? limit : value + coord_t'(1);
   endfunction

endpackage

// File: rtl/get_target_target_tracker.sv
// rtl/get_target_target_tracker.sv - run measurement and best-run capture for one colour
//
// Purpose : follows horizontal runs of pixels equal to COLOUR_CODE and keeps the
//           widest run seen in the current frame as a centre position + diameter.
// Ports   : clk_in, rst_in      clock, asynchronous active-high reset
//           line_start_in       vsync strobe; closes any open run before this pixel
//           frame_clear_in      vcount wrap; drops the best values
//           col_in              column of the pixel presented this cycle
//           row_in              line on which any closing run lies
//           rgb_in              compressed pixel
//           hcount_out, vcount_out, diameter_out, valid_out  registered best run

import get_target_pkg::*;

module target_tracker #(
   parameter rgb_t COLOUR_CODE  = RGB_RED,
   parameter int   MIN_DIAMETER = 4
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               line_start_in,
   input  logic               frame_clear_in,
   input  logic [COORD_W-1:0] col_in,
   input  logic [COORD_W-1:0] row_in,
   input  logic [2:0]         rgb_in,
   output logic [COORD_W-1:0] hcount_out,
   output logic [COORD_W-1:0] vcount_out,
   output logic [COORD_W-1:0] diameter_out,
   output logic               valid_out
);

   localparam coord_t MIN_D = coord_t'(MIN_DIAMETER);

   logic   run_active_q, run_active_d;
   coord_t run_start_q,  run_start_d;
   coord_t run_len_q,    run_len_d;
   coord_t best_h_q,     best_h_d;
   coord_t best_v_q,     best_v_d;
   coord_t best_len_q,   best_len_d;
   logic   valid_q,      valid_d;

   logic match;
   logic run_end;

   assign match   = (rgb_in == COLOUR_CODE);
   // A vsync always closes the open run, even if the new line's first pixel
   // matches; that pixel then opens a fresh run at column 0.
   assign run_end = run_active_q && (line_start_in || !match);

   always_comb begin
      run_active_d = run_active_q;
      run_start_d  = run_start_q;
      run_len_d    = run_len_q;
      best_h_d     = best_h_q;
      best_v_d     = best_v_q;
      best_len_d   = best_len_q;

      // Strictly greater: an equal-length later run leaves the earlier one in place.
      if (run_end && (run_len_q > best_len_q)) begin
         best_len_d = run_len_q;
         best_h_d   = run_start_q + (run_len_q >> 1);
         best_v_d   = row_in;
      end

      // Frame wrap wins over a run closing on the same strobe.
      if (frame_clear_in) begin
         best_len_d = '0;
         best_h_d   = '0;
         best_v_d   = '0;
      end

      if (match) begin
         if (run_active_q && !line_start_in) begin
            run_len_d = sat_inc(run_len_q, RUN_MAX);
         end else begin
            run_active_d = 1'b1;
            run_start_d  = col_in;
            run_len_d    = coord_t'(1);
         end
      end else begin
         run_active_d = 1'b0;
         run_len_d    = '0;
      end

      valid_d = (best_len_d >= MIN_D);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         run_active_q <= 1'b0;
         run_start_q  <= '0;
         run_len_q    <= '0;
         best_h_q     <= '0;
         best_v_q     <= '0;
         best_len_q   <= '0;
         valid_q      <= 1'b0;
      end else begin
         run_active_q <= run_active_d;
         run_start_q  <= run_start_d;
         run_len_q    <= run_len_d;
         best_h_q     <= best_h_d;
         best_v_q     <= best_v_d;
         best_len_q   <= best_len_d;
         valid_q      <= valid_d;
      end
   end

   assign hcount_out   = best_h_q;
   assign vcount_out   = best_v_q;
   assign diameter_out = best_len_q;
   assign valid_out    = valid_q;

endmodule

// File: rtl/get_target.sv
// rtl/get_target.sv - four-colour target locator on a compressed pixel stream
//
// Purpose : counts pixel column and line from the vsync strobe and feeds four
//           independent trackers, one per target colour.
// Ports   : clk_in, rst_in   clock, asynchronous active-high reset
//           vsync_in         line start; the pixel in that cycle is column 0
//           rgb_in           compressed pixel {R,G,B}
//           hcount_out[i], vcount_out[i], diameter_out[i], valid_out[i]
//                            best run centre, width and validity for target i

import get_target_pkg::*;

module get_target #(
   parameter int H_PIXELS     = 1680,
   parameter int V_LINES      = 1125,
   parameter int MIN_DIAMETER = 4
) (
   input  logic                                  clk_in,
   input  logic                                  rst_in,
   input  logic                                  vsync_in,
   input  logic [2:0]                            rgb_in,
   output logic [NUM_TARGETS-1:0][COORD_W-1:0]   hcount_out,
   output logic [NUM_TARGETS-1:0][COORD_W-1:0]   vcount_out,
   output logic [NUM_TARGETS-1:0][COORD_W-1:0]   diameter_out,
   output logic [NUM_TARGETS-1:0]                valid_out
);

   localparam coord_t H_LAST = coord_t'(H_PIXELS - 1);
   localparam coord_t V_LAST = coord_t'(V_LINES - 1);

   // hcount_q holds the column of the next pixel; vcount_q the current line.
   coord_t hcount_q, hcount_d;
   coord_t vcount_q, vcount_d;

   coord_t col_cur;
   logic   frame_clear;

   always_comb begin
      col_cur     = vsync_in ? '0 : hcount_q;
      hcount_d    = sat_inc(col_cur, H_LAST);
      vcount_d    = vcount_q;
      frame_clear = 1'b0;
      if (vsync_in) begin
         if (vcount_q == V_LAST) begin
            vcount_d    = '0;
            frame_clear = 1'b1;
         end else begin
            vcount_d    = vcount_q + coord_t'(1);
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         hcount_q <= '0;
         vcount_q <= '0;
      end else begin
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
      end
   end

   // A run closing this cycle lies on vcount_q, whether it ends on a
   // non-matching pixel or on the vsync that starts the next line.
   for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_tracker
      target_tracker #(
         .COLOUR_CODE  (TARGET_CODES[g]),
         .MIN_DIAMETER (MIN_DIAMETER)
      ) u_tracker (
         .clk_in         (clk_in),
         .rst_in         (rst_in),
         .line_start_in  (vsync_in),
         .frame_clear_in (frame_clear),
         .col_in         (col_cur),
         .row_in         (vcount_q),
         .rgb_in         (rgb_in),
         .hcount_out     (hcount_out[g]),
         .vcount_out     (vcount_out[g]),
         .diameter_out   (diameter_out[g]),
         .valid_out      (valid_out[g])
      );
   end

endmodule

// File: tb/tb_get_target.sv
// tb/tb_get_target.sv - directed self-checking bench for get_target

module tb_get_target;

   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] GREEN  = 3'b010;
   localparam logic [2:0] BLUE   = 3'b001;
   localparam logic [2:0] YELLOW = 3'b110;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              vsync = 1'b0;
   logic [2:0]        rgb = 3'b000;
   logic [3:0][10:0]  hcount_out;
   logic [3:0][10:0]  vcount_out;
   logic [3:0][10:0]  diameter_out;
   logic [3:0]        valid_out;

   int n_tests = 0;
   int n_fail  = 0;

   get_target dut (
      .clk_in       (clk),
      .rst_in       (rst),
      .vsync_in     (vsync),
      .rgb_in       (rgb),
      .hcount_out   (hcount_out),
      .vcount_out   (vcount_out),
      .diameter_out (diameter_out),
      .valid_out    (valid_out)
   );

   always #5 clk = ~clk;

   task automatic pix(input logic vs, input logic [2:0] c);
      vsync = vs;
      rgb   = c;
      @(posedge clk);
      #1;
   endtask

   task automatic emit_line(input int total, input int rs, input int rl, input logic [2:0] c);
      for (int col = 0; col < total; col++)
         pix(col == 0, (col >= rs && col < rs + rl) ? c : 3'b000);
   endtask

   task automatic test_reset;
      rgb = RED;
      #2 rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      n_tests++; if (diameter_out !== '0) begin n_fail++; $display("FAIL reset_diam got %h want 0", diameter_out); end
      n_tests++; if (hcount_out !== '0) begin n_fail++; $display("FAIL reset_hcount got %h want 0", hcount_out); end
      n_tests++; if (vcount_out !== '0) begin n_fail++; $display("FAIL reset_vcount got %h want 0", vcount_out); end
      n_tests++; if (valid_out !== 4'b0000) begin n_fail++; $display("FAIL reset_valid got %b want 0000", valid_out); end
      rgb = 3'b000;
      #3 rst = 1'b0;
   endtask

   task automatic test_black_frame;
      for (int l = 1; l <= 4; l++) emit_line(30, 0, 0, 3'b000);
      n_tests++; if (diameter_out !== '0) begin n_fail++; $display("FAIL black_diam got %h want 0", diameter_out); end
      n_tests++; if (valid_out !== 4'b0000) begin n_fail++; $display("FAIL black_valid got %b want 0000", valid_out); end
   endtask

   task automatic test_single_run;
      pix(1'b1, 3'b000);
      for (int col = 1; col <= 109; col++) pix(1'b0, (col >= 100) ? RED : 3'b000);
      n_tests++; if (diameter_out[0] !== 11'd0) begin n_fail++; $display("FAIL open_run_diam got %0d want 0", diameter_out[0]); end
      pix(1'b0, 3'b000);
      n_tests++; if (diameter_out[0] !== 11'd10) begin n_fail++; $display("FAIL single_diam got %0d want 10", diameter_out[0]); end
      n_tests++; if (hcount_out[0] !== 11'd105) begin n_fail++; $display("FAIL single_hcount got %0d want 105", hcount_out[0]); end
      n_tests++; if (vcount_out[0] !== 11'd5) begin n_fail++; $display("FAIL single_vcount got %0d want 5", vcount_out[0]); end
      n_tests++; if (valid_out !== 4'b0001) begin n_fail++; $display("FAIL single_valid got %b want 0001", valid_out); end
      for (int col = 111; col < 120; col++) pix(1'b0, 3'b000);
   endtask

   task automatic test_tie_then_wider;
      emit_line(40, 20, 10, RED);
      n_tests++; if (vcount_out[0] !== 11'd5) begin n_fail++; $display("FAIL tie_vcount got %0d want 5", vcount_out[0]); end
      n_tests++; if (hcount_out[0] !== 11'd105) begin n_fail++; $display("FAIL tie_hcount got %0d want 105", hcount_out[0]); end
      emit_line(70, 50, 12, RED);
      n_tests++; if (diameter_out[0] !== 11'd12) begin n_fail++; $display("FAIL wider_diam got %0d want 12", diameter_out[0]); end
      n_tests++; if (hcount_out[0] !== 11'd56) begin n_fail++; $display("FAIL wider_hcount got %0d want 56", hcount_out[0]); end
      n_tests++; if (vcount_out[0] !== 11'd7) begin n_fail++; $display("FAIL wider_vcount got %0d want 7", vcount_out[0]); end
   endtask

   task automatic test_short_green;
      emit_line(20, 10, 3, GREEN);
      n_tests++; if (diameter_out[1] !== 11'd3) begin n_fail++; $display("FAIL green_diam got %0d want 3", diameter_out[1]); end
      n_tests++; if (hcount_out[1] !== 11'd11) begin n_fail++; $display("FAIL green_hcount got %0d want 11", hcount_out[1]); end
      n_tests++; if (vcount_out[1] !== 11'd8) begin n_fail++; $display("FAIL green_vcount got %0d want 8", vcount_out[1]); end
      n_tests++; if (valid_out !== 4'b0001) begin n_fail++; $display("FAIL green_valid got %b want 0001", valid_out); end
      n_tests++; if (diameter_out[0] !== 11'd12) begin n_fail++; $display("FAIL green_red_kept got %0d want 12", diameter_out[0]); end
   endtask

   task automatic test_vsync_close;
      for (int col = 0; col < 1680; col++) pix(col == 0, (col >= 1670) ? BLUE : 3'b000);
      n_tests++; if (diameter_out[2] !== 11'd0) begin n_fail++; $display("FAIL edge_open_diam got %0d want 0", diameter_out[2]); end
      pix(1'b1, 3'b000);
      n_tests++; if (diameter_out[2] !== 11'd10) begin n_fail++; $display("FAIL edge_diam got %0d want 10", diameter_out[2]); end
      n_tests++; if (hcount_out[2] !== 11'd1675) begin n_fail++; $display("FAIL edge_hcount got %0d want 1675", hcount_out[2]); end
      n_tests++; if (vcount_out[2] !== 11'd9) begin n_fail++; $display("FAIL edge_vcount got %0d want 9", vcount_out[2]); end
      n_tests++; if (valid_out !== 4'b0101) begin n_fail++; $display("FAIL edge_valid got %b want 0101", valid_out); end
   endtask

   task automatic test_back_to_back;
      // Line 10 continues: yellow 25..29 runs into the next line's column 0.
      for (int col = 1; col < 30; col++) pix(1'b0, (col >= 25) ? YELLOW : 3'b000);
      pix(1'b1, YELLOW);
      n_tests++; if (diameter_out[3] !== 11'd5) begin n_fail++; $display("FAIL b2b_first_diam got %0d want 5", diameter_out[3]); end
      n_tests++; if (hcount_out[3] !== 11'd27) begin n_fail++; $display("FAIL b2b_first_hcount got %0d want 27", hcount_out[3]); end
      n_tests++; if (vcount_out[3] !== 11'd10) begin n_fail++; $display("FAIL b2b_first_vcount got %0d want 10", vcount_out[3]); end
      for (int col = 1; col <= 6; col++) pix(1'b0, YELLOW);
      pix(1'b0, 3'b000);
      n_tests++; if (diameter_out[3] !== 11'd7) begin n_fail++; $display("FAIL b2b_second_diam got %0d want 7", diameter_out[3]); end
      n_tests++; if (hcount_out[3] !== 11'd3) begin n_fail++; $display("FAIL b2b_second_hcount got %0d want 3", hcount_out[3]); end
      n_tests++; if (vcount_out[3] !== 11'd11) begin n_fail++; $display("FAIL b2b_second_vcount got %0d want 11", vcount_out[3]); end
      n_tests++; if (valid_out !== 4'b1101) begin n_fail++; $display("FAIL b2b_valid got %b want 1101", valid_out); end
   endtask

   task automatic test_reset_mid_run;
      pix(1'b1, 3'b000);
      for (int col = 1; col <= 20; col++) pix(1'b0, (col >= 5) ? RED : 3'b000);
      #2 rst = 1'b1;
      #1;
      n_tests++; if (diameter_out !== '0) begin n_fail++; $display("FAIL async_rst_diam got %h want 0", diameter_out); end
      n_tests++; if (valid_out !== 4'b0000) begin n_fail++; $display("FAIL async_rst_valid got %b want 0000", valid_out); end
      @(posedge clk); #2;
      rst = 1'b0;
      for (int col = 0; col <= 4; col++) pix(1'b0, RED);
      n_tests++; if (diameter_out[0] !== 11'd0) begin n_fail++; $display("FAIL post_rst_open got %0d want 0", diameter_out[0]); end
      pix(1'b0, 3'b000);
      n_tests++; if (diameter_out[0] !== 11'd5) begin n_fail++; $display("FAIL post_rst_diam got %0d want 5", diameter_out[0]); end
      n_tests++; if (hcount_out[0] !== 11'd2) begin n_fail++; $display("FAIL post_rst_hcount got %0d want 2", hcount_out[0]); end
      n_tests++; if (vcount_out[0] !== 11'd0) begin n_fail++; $display("FAIL post_rst_vcount got %0d want 0", vcount_out[0]); end
      n_tests++; if (valid_out !== 4'b0001) begin n_fail++; $display("FAIL post_rst_valid got %b want 0001", valid_out); end
   endtask

   task automatic test_frame_wrap;
      for (int l = 1; l <= 1123; l++) emit_line(6, 0, 0, 3'b000);
      emit_line(6, 1, 3, RED);
      n_tests++; if (diameter_out[0] !== 11'd5) begin n_fail++; $display("FAIL prewrap_diam got %0d want 5", diameter_out[0]); end
      n_tests++; if (vcount_out[0] !== 11'd0) begin n_fail++; $display("FAIL prewrap_vcount got %0d want 0", vcount_out[0]); end
      pix(1'b1, RED);
      n_tests++; if (diameter_out !== '0) begin n_fail++; $display("FAIL wrap_diam got %h want 0", diameter_out); end
      n_tests++; if (hcount_out !== '0) begin n_fail++; $display("FAIL wrap_hcount got %h want 0", hcount_out); end
      n_tests++; if (valid_out !== 4'b0000) begin n_fail++; $display("FAIL wrap_valid got %b want 0000", valid_out); end
      pix(1'b0, RED);
      pix(1'b0, RED);
      pix(1'b0, 3'b000);
      n_tests++; if (diameter_out[0] !== 11'd3) begin n_fail++; $display("FAIL fresh_diam got %0d want 3", diameter_out[0]); end
      n_tests++; if (hcount_out[0] !== 11'd1) begin n_fail++; $display("FAIL fresh_hcount got %0d want 1", hcount_out[0]); end
      n_tests++; if (vcount_out[0] !== 11'd0) begin n_fail++; $display("FAIL fresh_vcount got %0d want 0", vcount_out[0]); end
      n_tests++; if (valid_out !== 4'b0000) begin n_fail++; $display("FAIL fresh_valid got %b want 0000", valid_out); end
   endtask

   initial begin
      test_reset;
      test_black_frame;
      test_single_run;
      test_tie_then_wider;
      test_short_green;
      test_vsync_close;
      test_back_to_back;
      test_reset_mid_run;
      test_frame_wrap;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
